// File: rtl/regfile_mp.sv
// Two-write, two-read register file with hardwired zero register and a per-register
// busy scoreboard for RAW hazard detection. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy0,
    output logic              rbusy1,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_busy_any;
    logic [DEPTH-1:0]  w_busy_next;
    logic              w_wr0_ok;
    logic              w_wr1_ok;

    // Writes to the hardwired zero register are dropped before they reach the array.
    assign w_wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Clears are applied before the set so a newly issued producer keeps its bit.
    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        w_busy_next = r_busy;
        if (we0)
            w_busy_next[waddr0] = 1'b0;
        if (we1)
            w_busy_next[waddr1] = 1'b0;
        if (issue_valid)
            w_busy_next[issue_addr] = 1'b1;
        if (ZERO_REG != 0)
            w_busy_next[0] = 1'b0;
    end

    // NOTE: the array is reset here because the asynchronous clear is architectural;
    // this forces it into flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            // NOTE: non-blocking updates; when both ports hit one address the later
            // assignment (port 1) takes effect, which gives port 1 its priority.
            if (w_wr0_ok)
                r_regs[waddr0] <= wdata0;
            if (w_wr1_ok)
                r_regs[waddr1] <= wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_any <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_any <= |w_busy_next;
        end
    end

    assign busy_any = r_busy_any;

    always_comb begin
        rdata0 = r_regs[raddr0];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (waddr1 == raddr0))
            rdata0 = wdata1;
        else if (we0 && (waddr0 == raddr0))
            rdata0 = wdata0;
`endif
        if ((ZERO_REG != 0) && (raddr0 == '0))
            rdata0 = '0;
    end

    always_comb begin
        rdata1 = r_regs[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (waddr1 == raddr1))
            rdata1 = wdata1;
        else if (we0 && (waddr0 == raddr1))
            rdata1 = wdata0;
`endif
        if ((ZERO_REG != 0) && (raddr1 == '0))
            rdata1 = '0;
    end

    always_comb begin
        rbusy0 = r_busy[raddr0];
        rbusy1 = r_busy[raddr1];
`ifdef REGFILE_BYPASS_EN
        // An in-flight write resolves the hazard unless a newer producer issues alongside it.
        if (((we0 && (waddr0 == raddr0)) || (we1 && (waddr1 == raddr0)))
            && !(issue_valid && (issue_addr == raddr0)))
            rbusy0 = 1'b0;
        if (((we0 && (waddr0 == raddr1)) || (we1 && (waddr1 == raddr1)))
            && !(issue_valid && (issue_addr == raddr1)))
            rbusy1 = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations follow REGFILE_BYPASS_EN
// when the bench is compiled with it.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr0;
    logic [DATA_W-1:0] rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              rbusy0;
    logic              rbusy1;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy_any;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we0         (we0),
        .waddr0      (waddr0),
        .wdata0      (wdata0),
        .we1         (we1),
        .waddr1      (waddr1),
        .wdata1      (wdata1),
        .raddr0      (raddr0),
        .rdata0      (rdata0),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .rbusy0      (rbusy0),
        .rbusy1      (rbusy1),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_any    (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we0         = 1'b0;
        waddr0      = '0;
        wdata0      = '0;
        we1         = 1'b0;
        waddr1      = '0;
        wdata1      = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
        end
        checks++;
        if (rbusy0 !== 1'b0 || rbusy1 !== 1'b0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b%b%b want 000", rbusy0, rbusy1, busy_any);
        end
        rst_n = 1'b1;
        tick();
        raddr0 = 5'd5;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_addr = 5'd5;
        tick();
        idle();
        #1;
        checks++;
        if (rdata0 !== 32'hDEADBEEF || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL reset_prewrite: got %h busy_any %b want deadbeef 1", rdata0, busy_any);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata0 !== 32'h0 || busy_any !== 1'b0 || rbusy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %h busy_any %b rbusy0 %b want 0 0 0",
                     rdata0, busy_any, rbusy0);
        end
        repeat (3) tick();
        checks++;
        if (rdata0 !== 32'h0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h busy_any %b want 0 0", rdata0, busy_any);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_write();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        tick();
        idle();
        raddr0 = 5'd7;
        #1;
        checks++;
        if (rdata0 !== 32'h22222222) begin
            errors++;
            $display("FAIL dual_same_addr: got %h want 22222222", rdata0);
        end
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hAAAA0012;
        we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'hBBBB0013;
        tick();
        idle();
        raddr0 = 5'd12; raddr1 = 5'd13;
        #1;
        checks++;
        if (rdata0 !== 32'hAAAA0012 || rdata1 !== 32'hBBBB0013) begin
            errors++;
            $display("FAIL dual_diff_addr: got %h/%h want aaaa0012/bbbb0013", rdata0, rdata1);
        end
    endtask

    task automatic test_zero_reg();
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        raddr1 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_during_write: got %h want 0", rdata1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rbusy1 !== 1'b0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: got %h rbusy1 %b busy_any %b want 0 0 0",
                     rdata1, rbusy1, busy_any);
        end
    endtask

    task automatic test_scoreboard();
        raddr0 = 5'd3;
        issue_valid = 1'b1; issue_addr = 5'd3;
        tick();
        idle();
        #1;
        checks++;
        if (rbusy0 !== 1'b1 || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue: got rbusy0 %b busy_any %b want 1 1", rbusy0, busy_any);
        end
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h00000333;
        issue_valid = 1'b1; issue_addr = 5'd3;
        #1;
        checks++;
        if (rbusy0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_reissue_comb: got rbusy0 %b want 1", rbusy0);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rbusy0 !== 1'b1 || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: got rbusy0 %b busy_any %b want 1 1", rbusy0, busy_any);
        end
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h00000334;
        #1;
        checks++;
        if (rbusy0 !== !BYPASS) begin
            errors++;
            $display("FAIL sb_write_comb: got rbusy0 %b want %b", rbusy0, !BYPASS);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rbusy0 !== 1'b0 || busy_any !== 1'b0 || rdata0 !== 32'h00000334) begin
            errors++;
            $display("FAIL sb_clear: got rbusy0 %b busy_any %b data %h want 0 0 00000334",
                     rbusy0, busy_any, rdata0);
        end
        // Set one register while clearing a different, idle one.
        issue_valid = 1'b1; issue_addr = 5'd10;
        we0 = 1'b1; waddr0 = 5'd11; wdata0 = 32'h0000000B;
        tick();
        idle();
        raddr0 = 5'd10; raddr1 = 5'd11;
        #1;
        checks++;
        if (rbusy0 !== 1'b1 || rbusy1 !== 1'b0 || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL sb_diff_addr: got %b%b%b want 101", rbusy0, rbusy1, busy_any);
        end
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h0000000A;
        tick();
        idle();
        #1;
        checks++;
        if (rbusy0 !== 1'b0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear_p1: got rbusy0 %b busy_any %b want 0 0", rbusy0, busy_any);
        end
    endtask

    task automatic test_read_during_write();
        logic [DATA_W-1:0] exp_rdw;
        exp_rdw = BYPASS ? 32'hCAFEF00D : 32'h0;
        raddr0 = 5'd9;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hCAFEF00D;
        #1;
        checks++;
        if (rdata0 !== exp_rdw) begin
            errors++;
            $display("FAIL read_during_write: got %h want %h", rdata0, exp_rdw);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata0 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_after_write: got %h want cafef00d", rdata0);
        end
    endtask

    task automatic test_mid_reset();
        raddr0 = 5'd4;
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00001234;
        issue_valid = 1'b1; issue_addr = 5'd4;
        tick();
        idle();
        #1;
        checks++;
        if (rdata0 !== 32'h00001234 || rbusy0 !== 1'b1 || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: got %h rbusy0 %b busy_any %b want 00001234 1 1",
                     rdata0, rbusy0, busy_any);
        end
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00005555;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_any !== 1'b0 || rbusy0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: got busy_any %b rbusy0 %b want 0 0", busy_any, rbusy0);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_data: got %h want 0", rdata0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rdata0 !== 32'h0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL midrst_lost_write: got %h busy_any %b want 0 0", rdata0, busy_any);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        raddr0 = '0;
        raddr1 = '0;
        idle();
        #2;
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_read_during_write();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion want completion by 20000");
        $fatal(1, "timeout");
    end

endmodule
